display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Parametrised successor to the calculator's 8-digit display controller.
- Holds N_DIGITS BCD/glyph cells that are updated by commands: positional write, shift-in entry, backspace and clear.
- Drives one time-multiplexed 7-segment bus: shared active-low segments plus a one-hot active-low digit enable.
- Adds leading-zero blanking, a minus glyph, a decimal point, and overflow/error flags. Sits between the calculator datapath/keypad FSM and the board display pins.

Parameters:
- N_DIGITS, 8, number of display cells (2..16).
- SCAN_DIV, 50000, clock cycles each digit stays enabled (>=1).
- POS_W, $clog2(N_DIGITS), position index width (derived localparam, min 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  2  cmd_e: WR_POS, SHIFT_IN, BACKSPACE, CLEAR.
- cmd_dig  in  4  glyph code.
- cmd_pos  in  POS_W  target cell for WR_POS.
- lz_blank  in  1  enable leading-zero blanking.
- dp_en  in  1  decimal point enable.
- dp_pos  in  POS_W  cell that shows the decimal point.
- overflow  out  1  sticky; a significant digit was shifted out.
- err  out  1  sticky; an illegal write was rejected.
- digits_out  out  4*N_DIGITS  cell readback; cell i is at [4i+3:4i].
- an  out  N_DIGITS  one-hot active-low digit enable.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.

Behaviour:
- Glyph codes: 0-9 are decimal digits, 10 is minus, 15 is blank; 11-14 are illegal. Cell 0 is the rightmost digit.
- Reset (reset=0, asynchronous), all registered:
  - every cell = 0; overflow = 0; err = 0.
  - cmd_ready = 0 while reset is held, then 1 from the first clock after release.
  - prescaler = 0, scan index = 0.
  - an = all 1, seg = 7'h7F, dp = 1.
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready.
  - The cell update is visible on digits_out the next cycle.
  - cmd_ready is 0 for exactly the one cycle after an acceptance, so the maximum rate is one command per 2 cycles.
  - cmd_valid while cmd_ready=0 is ignored (not queued).
- WR_POS:
  - If cmd_pos < N_DIGITS and cmd_dig is legal: cell[cmd_pos] = cmd_dig.
  - Otherwise: no cell changes and err is set.
- SHIFT_IN:
  - Illegal cmd_dig: err is set, no shift.
  - Otherwise: cell[i] = cell[i-1] for i = N_DIGITS-1..1, and cell[0] = cmd_dig.
  - If the old cell[N_DIGITS-1] was not 0 and not 15, overflow is set. The MSB is dropped regardless.
- BACKSPACE: cell[i] = cell[i+1]; cell[N_DIGITS-1] = 0. Flags are unchanged.
- CLEAR: all cells = 0; overflow = 0; err = 0.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, the scan index advances by 1 mod N_DIGITS. With SCAN_DIV=1 the index advances every cycle.
  - an, seg and dp are registered from the current scan index k, so they lag the index by one cycle.
  - an = ~(1<<k).
  - seg = glyph(cell[k]), or blank if k is leading-blanked.
  - dp = ~(dp_en & dp_pos==k).
- Leading blank: cell k is blanked if lz_blank=1 AND k>0 AND cell[k]==0 AND every cell j>k is 0 or 15. Cell 0 is never blanked by this rule.
- Illegal or blank glyphs drive seg = 7'h7F. Minus drives only segment g (seg = 7'h3F).
- Cell writes and scanning are independent. A write takes effect on the next scan slot that reads that cell; there is no tearing within a slot.
- Reset mid-scan or mid-command: immediate return to the reset state. A command accepted on the same edge that reset asserts is lost.

Decomposition:
- display_pkg holds:
  - typedef enum logic [1:0] cmd_e {WR_POS, SHIFT_IN, BACKSPACE, CLEAR}.
  - localparams GLY_MINUS=4'd10 and GLY_BLANK=4'd15.
  - function glyph_legal().
- One combinational sub-module, seg7_decode: 4-bit glyph in, 7-bit active-low segments out.
- All state lives in display_scan_ctrl: cells, flags, ready, prescaler, scan index, output registers.

Test Plan (N_DIGITS=8, SCAN_DIV=4):
- Reset and entry: release reset, SHIFT_IN 1,2,3 every other cycle.
  - Required: digits_out = 32'h0000_0123 and cmd_ready toggles 1,0.
  - Required with lz_blank=1: during slots 3..7 an has the matching bit low and seg = 7'h7F; slot 0 shows 3 with seg = 7'h30 ({g..a}: b,c,d,a,g on).
- Overflow: SHIFT_IN 9 nine times.
  - Required: overflow = 1 after the 9th shift and digits_out = 32'h9999_9999.
  - Then CLEAR: overflow = 0 and digits_out = 0.
- Illegal writes:
  - WR_POS pos=3, dig=12 → err=1 and cells unchanged.
  - WR_POS pos=3, dig=10 → cell3 = minus; when slot 3 is scanned, seg = 7'h3F.
- Scan timing:
  - an sequence is FE, FD, FB, ..., 7F, FE, each value held exactly 4 cycles.
  - dp_en=1, dp_pos=2 → dp=0 only while an=FB.
- BACKSPACE on 32'h0000_0123 → 32'h0000_0012.
  - Then hold cmd_valid high continuously: exactly one command is accepted per 2 cycles.
- Async reset: assert reset mid-slot between clock edges.
  - Required: an = FF and cells = 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and glyph helpers for the multiplexed 7-segment display controller.
package display_pkg;

  typedef enum logic [1:0] {
    WR_POS    = 2'd0,
    SHIFT_IN  = 2'd1,
    BACKSPACE = 2'd2,
    CLEAR     = 2'd3
  } cmd_e;

  localparam logic [3:0] GLY_MINUS = 4'd10;
  localparam logic [3:0] GLY_BLANK = 4'd15;

  // Codes 11..14 have no glyph and are rejected on entry.
  function automatic logic glyph_legal(input logic [3:0] g);
    return (g <= GLY_MINUS) || (g == GLY_BLANK);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Glyph code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  logic [6:0] seg_on;

  always_comb begin
    seg_on = 7'h00;
    case (glyph)
      4'd0:      seg_on = 7'h3F;
      4'd1:      seg_on = 7'h06;
      4'd2:      seg_on = 7'h5B;
      4'd3:      seg_on = 7'h4F;
      4'd4:      seg_on = 7'h66;
      4'd5:      seg_on = 7'h6D;
      4'd6:      seg_on = 7'h7D;
      4'd7:      seg_on = 7'h07;
      4'd8:      seg_on = 7'h7F;
      4'd9:      seg_on = 7'h6F;
      GLY_MINUS: seg_on = 7'h40;
      default:   seg_on = 7'h00;
    endcase
    seg = ~seg_on;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit glyph store with command interface and a time-multiplexed,
// leading-zero-blanking 7-segment scan driver.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter  int N_DIGITS = 8,
  parameter  int SCAN_DIV = 50000,
  localparam int POS_W    = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  cmd_e                  cmd_op,
  input  logic [3:0]            cmd_dig,
  input  logic [POS_W-1:0]      cmd_pos,
  input  logic                  lz_blank,
  input  logic                  dp_en,
  input  logic [POS_W-1:0]      dp_pos,
  output logic                  overflow,
  output logic                  err,
  output logic [4*N_DIGITS-1:0] digits_out,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int               PRE_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [POS_W-1:0] SCAN_LAST = POS_W'(N_DIGITS - 1);

  logic [N_DIGITS-1:0][3:0] cells_q, cells_d;
  logic                     ovf_q, ovf_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;
  logic [PRE_W-1:0]         presc_q, presc_d;
  logic [POS_W-1:0]         scan_q, scan_d;
  logic [N_DIGITS-1:0]      an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;

  logic                     accept;
  logic                     pos_ok;
  logic                     dig_ok;
  logic [3:0]               msb_old;
  logic [N_DIGITS-1:0]      blank_vec;
  logic                     upper_empty;
  logic [3:0]               scan_glyph;

  assign accept  = cmd_valid & ready_q;
  assign pos_ok  = {1'b0, cmd_pos} < (POS_W + 1)'(N_DIGITS);
  assign dig_ok  = glyph_legal(cmd_dig);
  assign msb_old = cells_q[N_DIGITS-1];

  // Command path: one acceptance forces a single idle cycle on cmd_ready.
  always_comb begin
    cells_d = cells_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    ready_d = ~accept;
    if (accept) begin
      case (cmd_op)
        WR_POS: begin
          if (pos_ok && dig_ok) cells_d[cmd_pos] = cmd_dig;
          else                  err_d = 1'b1;
        end
        SHIFT_IN: begin
          if (!dig_ok) begin
            err_d = 1'b1;
          end else begin
            cells_d = {cells_q[N_DIGITS-2:0], cmd_dig};
            if (msb_old != 4'd0 && msb_old != GLY_BLANK) ovf_d = 1'b1;
          end
        end
        BACKSPACE: cells_d = {4'd0, cells_q[N_DIGITS-1:1]};
        CLEAR: begin
          cells_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  // A cell is blanked only while every more-significant cell is empty.
  always_comb begin
    blank_vec   = '0;
    upper_empty = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      blank_vec[k] = lz_blank && (k != 0) && (cells_q[k] == 4'd0) && upper_empty;
      upper_empty  = upper_empty && (cells_q[k] == 4'd0 || cells_q[k] == GLY_BLANK);
    end
  end

  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    scan_d  = scan_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + POS_W'(1);
    end
  end

  assign scan_glyph = blank_vec[scan_q] ? GLY_BLANK : cells_q[scan_q];

  seg7_decode u_seg7_decode (
    .glyph (scan_glyph),
    .seg   (seg_d)
  );

  always_comb begin
    an_d = ~(N_DIGITS'(1) << scan_q);
    dp_d = ~(dp_en && (dp_pos == scan_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cells_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      cells_q <= cells_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign overflow   = ovf_q;
  assign err        = err_q;
  assign digits_out = cells_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with N_DIGITS=8, SCAN_DIV=4.
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int N = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  cmd_e        cmd_op = WR_POS;
  logic [3:0]  cmd_dig = 4'd0;
  logic [2:0]  cmd_pos = 3'd0;
  logic        lz_blank = 1'b0;
  logic        dp_en = 1'b0;
  logic [2:0]  dp_pos = 3'd0;
  logic        overflow, err, dp;
  logic [31:0] digits_out;
  logic [7:0]  an;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        ovf;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [7:0] an;
    logic       dp;
  } scan_exp_t;

  exp_t      sb[$];
  scan_exp_t scan_sb[$];

  logic [3:0] m_cells[N];
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;

  display_scan_ctrl #(.N_DIGITS(8), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dig(cmd_dig), .cmd_pos(cmd_pos), .lz_blank(lz_blank),
    .dp_en(dp_en), .dp_pos(dp_pos), .overflow(overflow), .err(err),
    .digits_out(digits_out), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = m_cells[i];
    return r;
  endfunction

  function automatic logic legal(input logic [3:0] g);
    return (g < 4'd11) || (g == 4'd15);
  endfunction

  function automatic logic [6:0] seg_exp(input logic [3:0] g);
    case (g)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  4'd10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Blanked when below the most significant non-empty cell's position is not reached.
  function automatic logic exp_blank(input int k);
    int top = -1;
    for (int j = 0; j < N; j++)
      if (m_cells[j] != 4'd0 && m_cells[j] != 4'd15) top = j;
    return lz_blank && (k > 0) && (k > top) && (m_cells[k] == 4'd0);
  endfunction

  task automatic m_apply(input cmd_e op, input logic [3:0] dig, input logic [2:0] pos);
    case (op)
      WR_POS: if (legal(dig)) m_cells[pos] = dig; else m_err = 1'b1;
      SHIFT_IN: begin
        if (!legal(dig)) m_err = 1'b1;
        else begin
          if (m_cells[N-1] != 4'd0 && m_cells[N-1] != 4'd15) m_ovf = 1'b1;
          for (int i = N - 1; i > 0; i--) m_cells[i] = m_cells[i-1];
          m_cells[0] = dig;
        end
      end
      BACKSPACE: begin
        for (int i = 0; i < N - 1; i++) m_cells[i] = m_cells[i+1];
        m_cells[N-1] = 4'd0;
      end
      CLEAR: begin
        for (int i = 0; i < N; i++) m_cells[i] = 4'd0;
        m_ovf = 1'b0;
        m_err = 1'b0;
      end
    endcase
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_cells[i] = 4'd0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one command at a negedge once ready, push the model result, drop valid.
  task automatic do_cmd(input cmd_e op, input logic [3:0] dig, input logic [2:0] pos);
    exp_t e;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
      $fatal(1, "cmd_ready never rose");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dig   = dig;
    cmd_pos   = pos;
    m_apply(op, dig, pos);
    e.d = m_pack(); e.ovf = m_ovf; e.err = m_err;
    sb.push_back(e);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic sync_slot0();
    logic [7:0] prev = an;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (an == 8'hFE && prev != 8'hFE) return;
      prev = an;
    end
    $display("FAIL scan_sync_timeout got an=%h want FE", an);
    $fatal(1, "scan never reached slot 0");
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    #2 reset = 1'b0;
    m_reset();
    @(negedge clock);
    tests++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      fails++; $display("FAIL reset_outputs got an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
    end
    tests++;
    if ({digits_out, overflow, err, cmd_ready} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state got d=%h ovf=%b err=%b rdy=%b want 0 0 0 0",
                        digits_out, overflow, err, cmd_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_release got %b want 1", cmd_ready);
    end
    e = '0;
    sb.delete();
  endtask

  task automatic test_entry();
    exp_t e;
    logic [3:0] vals[3] = '{4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 3; i++) begin
      do_cmd(SHIFT_IN, vals[i], 3'd0);
      e = sb.pop_front();
      tests++;
      if ({digits_out, overflow, err} !== {e.d, e.ovf, e.err}) begin
        fails++; $display("FAIL entry_shift%0d got %h/%b/%b want %h/%b/%b", i,
                          digits_out, overflow, err, e.d, e.ovf, e.err);
      end
      tests++;
      if (cmd_ready !== 1'b0) begin
        fails++; $display("FAIL entry_ready_low%0d got %b want 0", i, cmd_ready);
      end
      @(negedge clock);
      tests++;
      if (cmd_ready !== 1'b1) begin
        fails++; $display("FAIL entry_ready_high%0d got %b want 1", i, cmd_ready);
      end
    end
    tests++;
    if (digits_out !== 32'h0000_0123) begin
      fails++; $display("FAIL entry_value got %h want 00000123", digits_out);
    end
    lz_blank = 1'b1;
    sync_slot0();
    for (int s = 0; s < N; s++) begin
      for (int c = 0; c < 4; c++) begin
        tests++;
        if (an !== ~(8'd1 << s) ||
            seg !== (exp_blank(s) ? 7'h7F : seg_exp(m_cells[s]))) begin
          fails++; $display("FAIL lz_slot%0d got an=%h seg=%h want an=%h seg=%h", s, an, seg,
                            ~(8'd1 << s), exp_blank(s) ? 7'h7F : seg_exp(m_cells[s]));
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    do_cmd(CLEAR, 4'd0, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 9; i++) begin
      do_cmd(SHIFT_IN, 4'd9, 3'd0);
      e = sb.pop_front();
      tests++;
      if ({digits_out, overflow, err} !== {e.d, e.ovf, e.err}) begin
        fails++; $display("FAIL ovf_shift%0d got %h/%b/%b want %h/%b/%b", i,
                          digits_out, overflow, err, e.d, e.ovf, e.err);
      end
    end
    tests++;
    if ({digits_out, overflow} !== {32'h9999_9999, 1'b1}) begin
      fails++; $display("FAIL ovf_final got %h/%b want 99999999/1", digits_out, overflow);
    end
    do_cmd(CLEAR, 4'd0, 3'd0);
    e = sb.pop_front();
    tests++;
    if ({digits_out, overflow, err} !== {32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL ovf_clear got %h/%b/%b want 0/0/0", digits_out, overflow, err);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    do_cmd(CLEAR, 4'd0, 3'd0);
    void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd1, 3'd0); void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd2, 3'd0); void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd3, 3'd0); void'(sb.pop_front());
    do_cmd(WR_POS, 4'd12, 3'd3);
    e = sb.pop_front();
    tests++;
    if ({digits_out, err} !== {32'h0000_0123, 1'b1} || {digits_out, overflow, err} !== {e.d, e.ovf, e.err}) begin
      fails++; $display("FAIL illegal_wr got %h/%b want 00000123/1", digits_out, err);
    end
    do_cmd(WR_POS, 4'd10, 3'd3);
    e = sb.pop_front();
    tests++;
    if ({digits_out, err} !== {32'h0000_A123, 1'b1}) begin
      fails++; $display("FAIL minus_wr got %h/%b want 0000A123/1", digits_out, err);
    end
    do_cmd(SHIFT_IN, 4'd11, 3'd0);
    e = sb.pop_front();
    tests++;
    if ({digits_out, overflow, err} !== {e.d, e.ovf, e.err}) begin
      fails++; $display("FAIL illegal_shift got %h/%b/%b want %h/%b/%b",
                        digits_out, overflow, err, e.d, e.ovf, e.err);
    end
    lz_blank = 1'b0;
    sync_slot0();
    repeat (12) @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      tests++;
      if ({an, seg} !== {8'hF7, 7'h3F}) begin
        fails++; $display("FAIL minus_seg got an=%h seg=%h want F7 3F", an, seg);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_scan();
    scan_exp_t x;
    dp_en  = 1'b1;
    dp_pos = 3'd2;
    for (int s = 0; s <= N; s++)
      for (int c = 0; c < 4; c++) begin
        x.an = ~(8'd1 << (s % N));
        x.dp = ((s % N) == 2) ? 1'b0 : 1'b1;
        scan_sb.push_back(x);
      end
    sync_slot0();
    while (scan_sb.size() > 0) begin
      x = scan_sb.pop_front();
      tests++;
      if ({an, dp} !== {x.an, x.dp}) begin
        fails++; $display("FAIL scan_seq got an=%h dp=%b want an=%h dp=%b", an, dp, x.an, x.dp);
      end
      @(negedge clock);
    end
    dp_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_cmd(CLEAR, 4'd0, 3'd0); void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd1, 3'd0); void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd2, 3'd0); void'(sb.pop_front());
    do_cmd(SHIFT_IN, 4'd3, 3'd0); void'(sb.pop_front());
    do_cmd(BACKSPACE, 4'd0, 3'd0);
    e = sb.pop_front();
    tests++;
    if ({digits_out, overflow, err} !== {32'h0000_0012, 1'b0, 1'b0}) begin
      fails++; $display("FAIL backspace got %h/%b/%b want 00000012/0/0", digits_out, overflow, err);
    end
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = SHIFT_IN;
    cmd_dig   = 4'd5;
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cmd_ready !== ((i % 2) == 0)) begin
        fails++; $display("FAIL b2b_ready%0d got %b want %b", i, cmd_ready, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        m_apply(SHIFT_IN, 4'd5, 3'd0);
        e.d = m_pack(); e.ovf = m_ovf; e.err = m_err;
        sb.push_back(e);
      end
      @(negedge clock);
      if ((i % 2) == 0) begin
        e = sb.pop_front();
        tests++;
        if ({digits_out, overflow, err} !== {e.d, e.ovf, e.err}) begin
          fails++; $display("FAIL b2b_data%0d got %h want %h", i, digits_out, e.d);
        end
      end
    end
    cmd_valid = 1'b0;
    tests++;
    if (digits_out !== 32'h1255_5555) begin
      fails++; $display("FAIL b2b_final got %h want 12555555", digits_out);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    m_reset();
    tests++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      fails++; $display("FAIL async_rst_out got an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
    end
    tests++;
    if ({digits_out, cmd_ready, overflow, err} !== {m_pack(), 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL async_rst_state got d=%h rdy=%b ovf=%b err=%b want 0 0 0 0",
                        digits_out, cmd_ready, overflow, err);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cells[i] = 4'd0;
    test_reset();
    test_entry();
    test_overflow();
    test_illegal();
    test_scan();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
